// File: rtl/usr_pkg.sv
// Shared encodings for the universal-shift-register command sequencer:
// USR ctrl/op codes, sequencer FSM states and a small op classification helper.
package usr_pkg;

  localparam logic [1:0] USR_HOLD = 2'b00;
  localparam logic [1:0] USR_SHR  = 2'b01;
  localparam logic [1:0] USR_SHL  = 2'b10;
  localparam logic [1:0] USR_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EXEC   = 2'b01,
    ST_SETTLE = 2'b10,
    ST_RESP   = 2'b11
  } seq_state_e;

  // Shift ops take their cycle count from the command; HOLD/LOAD always run one cycle.
  function automatic logic is_shift_op(input logic [1:0] op);
    return (op == USR_SHR) || (op == USR_SHL);
  endfunction

endpackage

// File: rtl/usr_cmd_sequencer.sv
// Turns one {op, count, data} command into a timed USR ctrl sequence and returns
// the settled USR contents on a valid/ready response channel.
module usr_cmd_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       usr_ctrl,
  output logic [WIDTH-1:0] usr_d,
  input  logic [WIDTH-1:0] usr_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] usr_d_q, usr_d_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  // Next-state and registered-output computation for the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_d      = ctrl_q;
    usr_d_d     = usr_d_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            USR_LOAD: begin
              usr_d_d = cmd_data;
              ctrl_d  = USR_LOAD;
              cnt_d   = CNT_ONE;
              state_d = ST_EXEC;
            end
            USR_HOLD: begin
              ctrl_d  = USR_HOLD;
              cnt_d   = CNT_ONE;
              state_d = ST_EXEC;
            end
            USR_SHR, USR_SHL: begin
              // A zero-length shift skips EXEC entirely and only waits for SETTLE.
              if (cmd_count == CNT_ZERO) begin
                ctrl_d  = USR_HOLD;
                cnt_d   = CNT_ZERO;
                state_d = ST_SETTLE;
              end else begin
                ctrl_d  = cmd_op;
                cnt_d   = cmd_count;
                state_d = ST_EXEC;
              end
            end
            default: begin
              ctrl_d  = USR_HOLD;
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_EXEC: begin
        if (cnt_q <= CNT_ONE) begin
          ctrl_d  = USR_HOLD;
          cnt_d   = CNT_ZERO;
          state_d = ST_SETTLE;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
          state_d = ST_EXEC;
        end
      end

      // ctrl has been HOLD for a full cycle, so usr_q now carries the final value.
      ST_SETTLE: begin
        rsp_data_d  = usr_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      default: begin
        ctrl_d      = USR_HOLD;
        cnt_d       = CNT_ZERO;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      ctrl_q      <= USR_HOLD;
      usr_d_q     <= {WIDTH{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      usr_d_q     <= usr_d_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign usr_ctrl  = ctrl_q;
  assign usr_d     = usr_d_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Randomized self-checking bench: a behavioural shift register sits beside the
// sequencer, and a transaction-level model predicts contents, latency and ctrl activity.
module tb_usr_cmd_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_count = 3'd0;
  logic [WIDTH-1:0] cmd_data = 4'd0;
  logic [1:0]       usr_ctrl;
  logic [WIDTH-1:0] usr_d;
  logic [WIDTH-1:0] usr_q;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q = 4'd0;
  logic [WIDTH-1:0] exp_d = 4'd0;

  always #5 clk = ~clk;

  usr_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_count(cmd_count), .cmd_data(cmd_data),
    .usr_ctrl(usr_ctrl), .usr_d(usr_d), .usr_q(usr_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
  );

  // Behavioural universal shift register sharing the reset net; shifts fill with 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) usr_q <= 4'd0;
    else begin
      case (usr_ctrl)
        2'b01:   usr_q <= usr_q >> 1;
        2'b10:   usr_q <= usr_q << 1;
        2'b11:   usr_q <= usr_d;
        default: usr_q <= usr_q;
      endcase
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic scramble_cmd();
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_count = 3'($urandom_range(0, 7));
    cmd_data  = 4'($urandom_range(0, 15));
  endtask

  // Called at a negedge with the sequencer idle; returns at the negedge after the handshake.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] cnt,
                         input logic [3:0] data, input int stall);
    int n, edges, nz, exp_nz;
    n      = (op == 2'b01 || op == 2'b10) ? int'(cnt) : 1;
    exp_nz = (op == 2'b00) ? 0 : n;
    case (op)
      2'b01:   exp_q = exp_q >> cnt;
      2'b10:   exp_q = exp_q << cnt;
      2'b11:   begin exp_q = data; exp_d = data; end
      default: exp_q = exp_q;
    endcase

    check_eq("cmd_ready_idle", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = data;
    @(posedge clk);
    edges = 0;
    nz    = 0;
    while (edges < 20) begin
      @(negedge clk);
      if (rsp_valid) break;
      check_eq("cmd_ready_busy", int'(cmd_ready), 0);
      if (usr_ctrl != 2'b00) begin
        nz++;
        check_eq("ctrl_op", int'(usr_ctrl), int'(op));
      end
      scramble_cmd();
      @(posedge clk);
      edges++;
    end
    check_eq("rsp_latency", edges, n + 1);
    check_eq("ctrl_active_cycles", nz, exp_nz);
    check_eq("rsp_data", int'(rsp_data), int'(exp_q));
    check_eq("usr_d", int'(usr_d), int'(exp_d));

    for (int i = 0; i < stall; i++) begin
      check_eq("stall_rsp_valid", int'(rsp_valid), 1);
      check_eq("stall_rsp_data", int'(rsp_data), int'(exp_q));
      check_eq("stall_cmd_ready", int'(cmd_ready), 0);
      check_eq("stall_ctrl", int'(usr_ctrl), 0);
      scramble_cmd();
      @(posedge clk);
      @(negedge clk);
    end

    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check_eq("post_hs_rsp_valid", int'(rsp_valid), 0);
    check_eq("post_hs_cmd_ready", int'(cmd_ready), 1);
    check_eq("post_hs_q", int'(usr_q), int'(exp_q));
  endtask

  task automatic run_random(input int count);
    for (int i = 0; i < count; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end
  endtask

  initial begin
    #3;
    check_eq("rst_ctrl", int'(usr_ctrl), 0);
    check_eq("rst_rsp_valid", int'(rsp_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_cmd_ready", int'(cmd_ready), 1);
    check_eq("rst_rsp_data", int'(rsp_data), 0);
    check_eq("rst_usr_d", int'(usr_d), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_cmd(2'b11, 3'd0, 4'b0110, 0);
    run_cmd(2'b01, 3'd2, 4'b1111, 0);
    run_cmd(2'b10, 3'd1, 4'b1010, 0);
    run_cmd(2'b10, 3'd0, 4'b0101, 0);
    run_cmd(2'b00, 3'd5, 4'b1001, 2);
    run_cmd(2'b01, 3'd1, 4'b1100, 5);
    run_cmd(2'b11, 3'd7, 4'b1111, 0);
    run_cmd(2'b01, 3'd7, 4'b0000, 1);

    run_random(40);

    // Reset arrives in the third EXEC cycle of a long shift.
    run_cmd(2'b11, 3'd0, 4'b1011, 0);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_count = 3'd7;
    cmd_data  = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_ctrl", int'(usr_ctrl), 0);
    check_eq("mid_rst_rsp_valid", int'(rsp_valid), 0);
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_cmd_ready", int'(cmd_ready), 1);
    check_eq("mid_rst_usr_d", int'(usr_d), 0);
    check_eq("mid_rst_rsp_data", int'(rsp_data), 0);
    exp_q = 4'd0;
    exp_d = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("post_rst_no_rsp", int'(rsp_valid), 0);
      check_eq("post_rst_cmd_ready", int'(cmd_ready), 1);
      check_eq("post_rst_ctrl", int'(usr_ctrl), 0);
    end

    run_cmd(2'b11, 3'd0, 4'b1001, 0);
    run_random(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
